// File: rtl/muxn_reg_pkg.sv
// Shared definitions for the channel mux: mode encodings and select-width helpers.
package muxn_reg_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // A select port must be at least one bit wide even for degenerate counts.
  function automatic int unsigned sel_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/muxn_reg_rr_grant.sv
// Combinational grant selection: direct select or round-robin from last+1.
module rr_grant
  import muxn_reg_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  input  logic             mode,
  input  logic [SEL_W-1:0] s,
  output logic [N-1:0]     grant
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (mode_e'(mode) == MODE_DIRECT) begin
      // Out-of-range selects match no channel, leaving grant all zero.
      for (int unsigned k = 0; k < N; k++) begin
        if (s == SEL_W'(k)) grant[k] = 1'b1;
      end
    end else begin
      for (int unsigned i = 1; i <= N; i++) begin
        idx = (32'(last) + i) % N;
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/muxn_reg.sv
// N-channel mux with one registered output stage and valid/ready handshake.
module muxn_reg
  import muxn_reg_pkg::*;
#(
  parameter  int          WIDTH    = 8,
  parameter  int          CHANNELS = 4,
  localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          s,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          o,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [SEL_W-1:0]          o_chan
);

  logic [CHANNELS-1:0] grant;
  logic                can_load;
  logic                xfer;
  logic [WIDTH-1:0]    sel_data;
  logic [SEL_W-1:0]    sel_idx;

  logic [WIDTH-1:0]    o_q,       o_d;
  logic                o_valid_q, o_valid_d;
  logic [SEL_W-1:0]    o_chan_q,  o_chan_d;
  logic [SEL_W-1:0]    last_q,    last_d;

  rr_grant #(
    .N     (CHANNELS),
    .SEL_W (SEL_W)
  ) u_grant (
    .req   (in_valid),
    .last  (last_q),
    .mode  (mode),
    .s     (s),
    .grant (grant)
  );

  always_comb begin
    can_load = !o_valid_q || o_ready;
    in_ready = reset ? '0 : (grant & {CHANNELS{can_load}});
    xfer     = |(in_valid & in_ready);
    sel_data = '0;
    sel_idx  = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (grant[k]) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_idx  = SEL_W'(k);
      end
    end
  end

  always_comb begin
    o_d       = o_q;
    o_chan_d  = o_chan_q;
    o_valid_d = o_valid_q;
    last_d    = last_q;
    if (xfer) begin
      o_d       = sel_data;
      o_chan_d  = sel_idx;
      o_valid_d = 1'b1;
      last_d    = sel_idx;
    end else if (o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // last_q resets to the top channel so the first round-robin grant is channel 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_q       <= '0;
      o_chan_q  <= '0;
      o_valid_q <= 1'b0;
      last_q    <= SEL_W'(CHANNELS - 1);
    end else begin
      o_q       <= o_d;
      o_chan_q  <= o_chan_d;
      o_valid_q <= o_valid_d;
      last_q    <= last_d;
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign o_chan  = o_chan_q;

endmodule

// File: doc/muxn_reg.md
MUXN_REG -- requirements
Module: muxn_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 SHALL have derived localparam SEL_W = clog2(CHANNELS), minimum 1.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port mode  input  1  0 = direct select, 1 = round-robin.
REQ-007 SHALL have port s  input  SEL_W  channel select, used in direct mode only.
REQ-008 SHALL have port in_data  input  CHANNELS*WIDTH  packed channel data; channel k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port in_valid  input  CHANNELS  per-channel data-valid.
REQ-010 SHALL have port in_ready  output  CHANNELS  per-channel accept, one-hot or zero, combinational.
REQ-011 SHALL have port o  output  WIDTH  registered output data.
REQ-012 SHALL have port o_valid  output  1  o holds an unconsumed word.
REQ-013 SHALL have port o_ready  input  1  downstream accepts o this cycle.
REQ-014 SHALL have port o_chan  output  SEL_W  source channel of the word in o.

Function
REQ-015 SHALL have one output register stage; a word is taken from a channel on the edge where in_valid[k] && in_ready[k]; latency 1 cycle to o_valid.
REQ-016 SHALL have can_load = !o_valid || o_ready; no in_ready bit may be high when can_load is 0.
REQ-017 SHALL, in direct mode, assert in_ready[s] = can_load; all other bits 0.
REQ-018 SHALL, in direct mode with s >= CHANNELS (non-power-of-2 CHANNELS), drive in_ready all 0 and load nothing.
REQ-019 SHALL, in round-robin mode, grant the first channel with in_valid set, searching upward from last_grant+1 with wrap from CHANNELS-1 to 0; in_ready[grant] = can_load.
REQ-020 SHALL update last_grant only on an accepted transfer, in either mode; direct-mode transfers also update it.
REQ-021 SHALL, in round-robin mode with no in_valid set, drive in_ready all 0 and leave last_grant unchanged.
REQ-022 SHALL, on a transfer, load o, o_chan, and set o_valid = 1.
REQ-023 SHALL, on o_ready with no new transfer, clear o_valid and hold o and o_chan.
REQ-024 SHALL, on simultaneous o_ready and a new transfer, replace o with no bubble, sustaining 1 word/cycle.
REQ-025 SHALL, while o_valid && !o_ready, hold o, o_chan, and o_valid stable.
REQ-026 SHALL apply mode and s changes only to the next grant decision; a held output word is unaffected.
REQ-027 SHALL have no combinational path from in_data to o.

Reset
REQ-028 SHALL, on reset, asynchronously force o = 0, o_chan = 0, o_valid = 0, last_grant = CHANNELS-1 (first round-robin grant favours channel 0).
REQ-029 SHALL drive in_ready all 0 while reset is high; any word held mid-transfer is discarded.

Structure
REQ-030 SHALL take clog2 and the mode encodings (MODE_DIRECT = 0, MODE_RR = 1) from the shared include/package used by the CPLD designs.
REQ-031 SHALL implement grant selection as sub-module rr_grant (inputs req, last, mode, s; output one-hot grant), purely combinational; the register stage stays in muxn_reg.

Verification
REQ-032 SHALL cover direct mode: W=8, N=4, s=2, in_valid=0100, ch2=0xA5, o_ready=1 -> next cycle o=0xA5, o_chan=2, o_valid=1; in_ready=0100 only.
REQ-033 SHALL cover round-robin fairness: mode=1, in_valid=1111 held, o_ready=1 -> o_chan sequence 0,1,2,3,0 after reset, one word per cycle.
REQ-034 SHALL cover backpressure: o_valid=1, o_ready=0 for 3 cycles -> in_ready=0000, o unchanged; release o_ready -> transfer resumes next cycle with no word lost or duplicated.
REQ-035 SHALL cover wrap and skip: mode=1, last_grant=3, in_valid=0100 -> grant ch2; then in_valid=1010 -> grant ch3, then ch1.
REQ-036 SHALL cover invalid select: N=3, mode=0, s=3, in_valid=111 -> in_ready=000, o_valid stays 0.
REQ-037 SHALL cover async reset: reset asserted mid-cycle while o_valid=1 -> o_valid=0, o=0, o_chan=0 before the next edge; first round-robin grant after release = ch0.
